lector_salida_rr: RTL and testbench

// Reader at the far end of the four output FIFOs that the arbiter fills. Pops the
// non-empty FIFOs in round-robin order and delivers one word per cycle on a

---
 rtl/lector_salida_rr_if.sv | 44 ++++
 rtl/lector_salida_rr.sv | 144 ++++++++++++++
 tb/tb_lector_salida_rr.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lector_salida_rr_if.sv
// rtl/lector_salida_rr_if.sv - FIFO-side and stream-side signal bundle for lector_salida_rr
interface lector_salida_rr_if #(
  parameter int FIFO_WORD_SIZE = 10,
  parameter int CNT_WIDTH      = 5
);
  logic                      enable;
  logic                      empty_p0;
  logic                      empty_p1;
  logic                      empty_p2;
  logic                      empty_p3;
  logic [FIFO_WORD_SIZE-1:0] data_in_0;
  logic [FIFO_WORD_SIZE-1:0] data_in_1;
  logic [FIFO_WORD_SIZE-1:0] data_in_2;
  logic [FIFO_WORD_SIZE-1:0] data_in_3;
  logic                      ready_in;
  logic                      req;
  logic [1:0]                idx;
  logic                      pop_p0;
  logic                      pop_p1;
  logic                      pop_p2;
  logic                      pop_p3;
  logic [FIFO_WORD_SIZE-1:0] data_out;
  logic                      valid_out;
  logic [1:0]                port_out;
  logic [CNT_WIDTH-1:0]      count_out;
  logic                      count_valid;
  logic                      idle;

  modport slave (
    input  enable, empty_p0, empty_p1, empty_p2, empty_p3,
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    input  ready_in, req, idx,
    output pop_p0, pop_p1, pop_p2, pop_p3,
    output data_out, valid_out, port_out, count_out, count_valid, idle
  );

  modport master (
    output enable, empty_p0, empty_p1, empty_p2, empty_p3,
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output ready_in, req, idx,
    input  pop_p0, pop_p1, pop_p2, pop_p3,
    input  data_out, valid_out, port_out, count_out, count_valid, idle
  );
endinterface

// File: rtl/lector_salida_rr.sv
// rtl/lector_salida_rr.sv - round-robin reader of four output FIFOs into a tagged valid/ready stream
module lector_salida_rr #(
  parameter int FIFO_WORD_SIZE = 10,
  parameter int CNT_WIDTH      = 5
) (
  input logic               clk,
  input logic               reset,
  lector_salida_rr_if.slave bus
);
  localparam int W = FIFO_WORD_SIZE;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t               r_state;
  logic                 r_idle;
  logic [1:0]           r_occ;
  logic                 r_inflight;
  logic [1:0]           r_inflight_port;
  logic [W-1:0]         r_buf_data [2];
  logic [1:0]           r_buf_port [2];
  logic [1:0]           r_rr;
  logic [CNT_WIDTH-1:0] r_cnt [4];
  logic [CNT_WIDTH-1:0] r_count_out;
  logic                 r_count_valid;

  logic [3:0]   w_nonempty;
  logic         w_transfer;
  logic [2:0]   w_level;
  logic         w_can_pop;
  logic [1:0]   w_grant;
  logic         w_found;
  logic [3:0]   w_pop;
  logic         w_wr_idx;
  logic [W-1:0] w_rd_data;

  assign w_nonempty = ~{bus.empty_p3, bus.empty_p2, bus.empty_p1, bus.empty_p0};
  assign w_transfer = (r_occ != 2'd0) & bus.ready_in;
  // Occupancy after this edge once the in-flight word lands; never underflows
  // because a transfer implies occ >= 1.
  assign w_level    = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_transfer};
  assign w_can_pop  = !reset & bus.enable & (w_level < 3'd2) & (|w_nonempty);
  // occ == 2 never coincides with an in-flight word, so slot 1 is the only other target.
  assign w_wr_idx   = (r_occ != 2'd0) & !w_transfer;

  always_comb begin
    w_grant = r_rr;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && w_nonempty[r_rr + 2'(k)]) begin
        w_grant = r_rr + 2'(k);
        w_found = 1'b1;
      end
    end
  end

  assign w_pop = w_can_pop ? (4'b0001 << w_grant) : 4'b0000;

  always_comb begin
    case (r_inflight_port)
      2'd0:    w_rd_data = bus.data_in_0;
      2'd1:    w_rd_data = bus.data_in_1;
      2'd2:    w_rd_data = bus.data_in_2;
      default: w_rd_data = bus.data_in_3;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ           <= 2'd0;
      r_inflight      <= 1'b0;
      r_inflight_port <= 2'd0;
      r_rr            <= 2'd3;
      r_count_out     <= '0;
      r_count_valid   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_port[i] <= 2'd0;
      end
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_occ      <= w_level[1:0];
      r_inflight <= w_can_pop;
      if (w_can_pop) begin
        r_inflight_port <= w_grant;
        r_rr            <= w_grant;
      end
      if (w_transfer) begin
        r_buf_data[0] <= r_buf_data[1];
        r_buf_port[0] <= r_buf_port[1];
      end
      if (r_inflight) begin
        r_buf_data[w_wr_idx] <= w_rd_data;
        r_buf_port[w_wr_idx] <= r_inflight_port;
      end
      if (w_transfer && (r_cnt[r_buf_port[0]] != {CNT_WIDTH{1'b1}})) begin
        r_cnt[r_buf_port[0]] <= r_cnt[r_buf_port[0]] + 1'b1;
      end
      // Reads the pre-increment value by construction of non-blocking update.
      r_count_valid <= bus.req;
      if (bus.req) begin
        r_count_out <= r_cnt[bus.idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idle  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((|w_nonempty) && bus.enable) begin
            r_state <= S_ACTIVE;
            r_idle  <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if ((!(|w_nonempty) || !bus.enable) && (r_occ == 2'd0) && !r_inflight) begin
            r_state <= S_IDLE;
            r_idle  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idle  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pop_p0      = w_pop[0];
  assign bus.pop_p1      = w_pop[1];
  assign bus.pop_p2      = w_pop[2];
  assign bus.pop_p3      = w_pop[3];
  assign bus.data_out    = r_buf_data[0];
  assign bus.port_out    = r_buf_port[0];
  assign bus.valid_out   = (r_occ != 2'd0);
  assign bus.count_out   = r_count_out;
  assign bus.count_valid = r_count_valid;
  assign bus.idle        = r_idle;
endmodule

// File: tb/tb_lector_salida_rr.sv
// tb/tb_lector_salida_rr.sv - self-checking bench for lector_salida_rr against a queue-based model
module tb_lector_salida_rr;
  localparam int W      = 10;
  localparam int CW     = 5;
  localparam int CNTMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [1:0]   port;
    logic [W-1:0] data;
  } word_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lector_salida_rr_if #(.FIFO_WORD_SIZE(W), .CNT_WIDTH(CW)) bus();
  lector_salida_rr #(.FIFO_WORD_SIZE(W), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] f0[$], f1[$], f2[$], f3[$];

  word_t        mq[$];
  bit           m_infl;
  word_t        m_infl_w;
  int           m_rr;
  int           m_cnt[4];
  bit           m_idle;
  int           m_co;
  bit           m_cv;
  logic [3:0]   last_pop;
  int           cyc;
  int           first_pop, first_valid;
  int           pop_log[$], pop_cyc[$], tx_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  function automatic int fsize(input int p);
    case (p)
      0: return f0.size();
      1: return f1.size();
      2: return f2.size();
      default: return f3.size();
    endcase
  endfunction

  function automatic logic [W-1:0] ffront(input int p);
    case (p)
      0: return f0[0];
      1: return f1[0];
      2: return f2[0];
      default: return f3[0];
    endcase
  endfunction

  task automatic refresh_empty();
    bus.empty_p0 = (f0.size() == 0);
    bus.empty_p1 = (f1.size() == 0);
    bus.empty_p2 = (f2.size() == 0);
    bus.empty_p3 = (f3.size() == 0);
  endtask

  task automatic fpush(input int p, input logic [W-1:0] w);
    case (p)
      0: f0.push_back(w);
      1: f1.push_back(w);
      2: f2.push_back(w);
      default: f3.push_back(w);
    endcase
    refresh_empty();
  endtask

  task automatic fifo_apply(input logic [3:0] p);
    if (p[0] && f0.size() != 0) bus.data_in_0 = f0.pop_front();
    if (p[1] && f1.size() != 0) bus.data_in_1 = f1.pop_front();
    if (p[2] && f2.size() != 0) bus.data_in_2 = f2.pop_front();
    if (p[3] && f3.size() != 0) bus.data_in_3 = f3.pop_front();
    refresh_empty();
  endtask

  task automatic model_reset();
    mq.delete();
    m_infl = 0;
    m_rr   = 3;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_idle = 1;
    m_co   = 0;
    m_cv   = 0;
  endtask

  task automatic clear_logs();
    first_pop   = -1;
    first_valid = -1;
    pop_log.delete();
    pop_cyc.delete();
    tx_log.delete();
  endtask

  task automatic model_cycle();
    logic [3:0] ne, dpop, epop;
    int  g, lvl, occ0;
    bit  found, tr, infl0;
    word_t hw;
    ne    = {fsize(3) != 0, fsize(2) != 0, fsize(1) != 0, fsize(0) != 0};
    occ0  = mq.size();
    infl0 = m_infl;
    tr    = (occ0 != 0) && bus.ready_in;
    chk("valid_out", 32'(bus.valid_out), 32'(occ0 != 0));
    if (occ0 != 0) begin
      chk("data_out", 32'(bus.data_out), 32'(mq[0].data));
      chk("port_out", 32'(bus.port_out), 32'(mq[0].port));
    end
    chk("idle", 32'(bus.idle), 32'(m_idle));
    chk("count_valid", 32'(bus.count_valid), 32'(m_cv));
    chk("count_out", 32'(bus.count_out), 32'(m_co));
    found = 0;
    g     = 0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && ne[(m_rr + k) % 4]) begin
        g     = (m_rr + k) % 4;
        found = 1;
      end
    end
    lvl  = occ0 + int'(infl0) - int'(tr);
    epop = (bus.enable && lvl < 2 && found) ? (4'b0001 << g) : 4'b0000;
    dpop = {bus.pop_p3, bus.pop_p2, bus.pop_p1, bus.pop_p0};
    chk("pop", 32'(dpop), 32'(epop));
    last_pop = dpop;
    if (epop != 0) begin
      pop_log.push_back(g);
      pop_cyc.push_back(cyc);
      if (first_pop < 0) first_pop = cyc;
    end
    if (occ0 != 0 && first_valid < 0) first_valid = cyc;
    if (bus.req) m_co = m_cnt[bus.idx];
    m_cv = bus.req;
    if (tr) begin
      hw = mq.pop_front();
      tx_log.push_back(int'(hw.port));
      if (m_cnt[hw.port] != CNTMAX) m_cnt[hw.port]++;
    end
    if (m_infl) mq.push_back(m_infl_w);
    m_infl = (epop != 0);
    if (m_infl) begin
      m_infl_w = {2'(g), ffront(g)};
      m_rr     = g;
    end
    if (m_idle) begin
      if (ne != 0 && bus.enable) m_idle = 0;
    end else if ((ne == 0 || !bus.enable) && occ0 == 0 && !infl0) begin
      m_idle = 1;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    fifo_apply(last_pop);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_pops", 32'({bus.pop_p3, bus.pop_p2, bus.pop_p1, bus.pop_p0}), 32'd0);
    chk("rst_idle", 32'(bus.idle), 32'd1);
    chk("rst_count_valid", 32'(bus.count_valid), 32'd0);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic read_count(input int p, input int exp_lit, input string name);
    bus.req = 1'b1;
    bus.idx = 2'(p);
    step();
    bus.req = 1'b0;
    chk({name, "_value"}, 32'(bus.count_out), 32'(exp_lit));
    chk({name, "_pulse"}, 32'(bus.count_valid), 32'd1);
    step();
    chk({name, "_pulse_end"}, 32'(bus.count_valid), 32'd0);
  endtask

  initial begin
    int exp_order[8];
    logic [W-1:0] held;
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    reset = 1'b0;
    bus.enable = 1'b0; bus.ready_in = 1'b0; bus.req = 1'b0; bus.idx = 2'd0;
    bus.data_in_0 = '0; bus.data_in_1 = '0; bus.data_in_2 = '0; bus.data_in_3 = '0;
    refresh_empty();
    cyc = 0;
    clear_logs();
    #2 reset = 1'b1;
    #20;
    chk("init_valid_out", 32'(bus.valid_out), 32'd0);
    chk("init_port_out", 32'(bus.port_out), 32'd0);
    chk("init_count_out", 32'(bus.count_out), 32'd0);
    chk("init_idle", 32'(bus.idle), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single port: three back-to-back pops, two-cycle latency, count of three.
    bus.enable = 1'b1; bus.ready_in = 1'b1;
    for (int i = 0; i < 3; i++) fpush(2, W'(10'h200 + i));
    run(8);
    chk("t1_pops", 32'(pop_log.size()), 32'd3);
    chk("t1_back_to_back", 32'(pop_cyc[2] - pop_cyc[0]), 32'd2);
    chk("t1_latency", 32'(first_valid - first_pop), 32'd2);
    chk("t1_tx", 32'(tx_log.size()), 32'd3);
    read_count(2, 3, "t1_cnt2");

    // All four ports, two words each: strict rotation from port 0.
    do_reset();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 4; p++) fpush(p, W'(p * 16 + i));
    run(14);
    chk("t2_pop_count", 32'(pop_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_pop_order", 32'(pop_log[i]), 32'(exp_order[i]));
      chk("t2_port_order", 32'(tx_log[i]), 32'(exp_order[i]));
    end

    // Downstream stall: output holds, at most two buffered, nothing lost after release.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fpush(0, W'(10'h0A0 + i));
      fpush(3, W'(10'h3C0 + i));
    end
    run(3);
    bus.ready_in = 1'b0;
    held = bus.data_out;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_stall_hold", 32'(bus.data_out), 32'(held));
    end
    chk("t3_buffered", 32'(mq.size()), 32'd2);
    bus.ready_in = 1'b1;
    run(10);
    chk("t3_tx_total", 32'(tx_log.size()), 32'd6);

    // Counter saturation on port 1.
    do_reset();
    for (int i = 0; i < 40; i++) fpush(1, W'(i));
    run(46);
    chk("t4_tx_total", 32'(tx_log.size()), 32'd40);
    read_count(1, 31, "t4_sat");

    // Enable dropped mid-burst: three popped words still come out, then idle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fpush(0, W'(10'h100 + i));
      fpush(1, W'(10'h140 + i));
    end
    run(3);
    bus.enable = 1'b0;
    run(6);
    chk("t5_pops", 32'(pop_log.size()), 32'd3);
    chk("t5_tx", 32'(tx_log.size()), 32'd3);
    chk("t5_idle", 32'(bus.idle), 32'd1);

    // Reset with a full buffer; counters must clear.
    bus.enable = 1'b1;
    bus.ready_in = 1'b0;
    for (int i = 0; i < 3; i++) fpush(3, W'(10'h2F0 + i));
    run(4);
    chk("t6_full_before_reset", 32'(mq.size()), 32'd2);
    do_reset();
    bus.enable = 1'b0;
    read_count(0, 0, "t6_cnt0");
    read_count(1, 0, "t6_cnt1");

    // Randomized traffic.
    bus.enable = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 4) fpush(int'($urandom_range(0, 3)), W'($urandom));
      bus.ready_in = ($urandom_range(0, 3) != 0);
      bus.enable   = ($urandom_range(0, 7) != 0);
      bus.req      = ($urandom_range(0, 4) == 0);
      bus.idx      = 2'($urandom_range(0, 3));
      step();
    end
    bus.enable = 1'b1; bus.ready_in = 1'b1; bus.req = 1'b0;
    run(200);
    chk("rand_drained", 32'(mq.size() + fsize(0) + fsize(1) + fsize(2) + fsize(3)), 32'd0);
    chk("rand_idle", 32'(bus.idle), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
